// File: rtl/ensemble_vote_ctrl_if.sv
// AXI-Stream bundle shared by the feature, result and vote streams of the ensemble controller.
// The master side drives payload and valid; the slave side returns ready.
interface ensemble_vote_ctrl_if #(
  parameter int DW = 32,
  parameter int KW = 4
);
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ensemble_vote_ctrl.sv
// Ensemble sequencer: fans one feature frame out to the enabled classifiers, gathers one
// result per classifier, majority-votes the class label and emits one vote word per frame.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | latch classifier mask (000 treated as 111), start a frame
//  FEED    | broadcast feature beats; stall until every enabled copy taken
//  COLLECT | accept one result word per enabled classifier, any order
//  VOTE    | register voted label with tie/unanimous flags
//  OUT     | hold vote word on m_axis until accepted, count the frame
module ensemble_vote_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          en_mask,
  ensemble_vote_ctrl_if.slave  s_axis,
  ensemble_vote_ctrl_if.master f1_axis,
  ensemble_vote_ctrl_if.master f2_axis,
  ensemble_vote_ctrl_if.master f3_axis,
  ensemble_vote_ctrl_if.slave  r1_axis,
  ensemble_vote_ctrl_if.slave  r2_axis,
  ensemble_vote_ctrl_if.slave  r3_axis,
  ensemble_vote_ctrl_if.master m_axis,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic                proto_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_COLLECT = 3'd2,
    S_VOTE    = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             mask_q, mask_d;
  logic [2:0]             taken_q, taken_d;
  logic [2:0]             got_q, got_d;
  logic [CLASS_WIDTH-1:0] lab_q [3];
  logic [CLASS_WIDTH-1:0] lab_d [3];
  logic [CLASS_WIDTH+1:0] res_q, res_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   proto_err_q, proto_err_d;

  logic [2:0]             f_ready, f_valid;
  logic [2:0]             r_valid, r_last, r_ready, r_hs;
  logic [CLASS_WIDTH-1:0] r_lab [3];
  logic                   s_ready, s_hs, m_valid;

  logic                   e01, e02, e12, any_eq, all_eq, multi;
  logic [CLASS_WIDTH-1:0] v_label;
  logic                   v_unan, v_tie;

  assign f_ready  = {f3_axis.tready, f2_axis.tready, f1_axis.tready};
  assign r_valid  = {r3_axis.tvalid, r2_axis.tvalid, r1_axis.tvalid};
  assign r_last   = {r3_axis.tlast, r2_axis.tlast, r1_axis.tlast};
  assign r_lab[0] = r1_axis.tdata[CLASS_WIDTH-1:0];
  assign r_lab[1] = r2_axis.tdata[CLASS_WIDTH-1:0];
  assign r_lab[2] = r3_axis.tdata[CLASS_WIDTH-1:0];

  // Vote over the captured labels; only pairs of enabled classifiers can agree.
  always_comb begin
    e01    = mask_q[0] & mask_q[1] & (lab_q[0] == lab_q[1]);
    e02    = mask_q[0] & mask_q[2] & (lab_q[0] == lab_q[2]);
    e12    = mask_q[1] & mask_q[2] & (lab_q[1] == lab_q[2]);
    any_eq = e01 | e02 | e12;
    all_eq = (~(mask_q[0] & mask_q[1]) | (lab_q[0] == lab_q[1])) &
             (~(mask_q[0] & mask_q[2]) | (lab_q[0] == lab_q[2])) &
             (~(mask_q[1] & mask_q[2]) | (lab_q[1] == lab_q[2]));
    multi  = (mask_q[0] & mask_q[1]) | (mask_q[0] & mask_q[2]) | (mask_q[1] & mask_q[2]);
    if (any_eq) begin
      v_label = (e01 | e02) ? lab_q[0] : lab_q[1];
    end else if (mask_q[0]) begin
      v_label = lab_q[0];
    end else if (mask_q[1]) begin
      v_label = lab_q[1];
    end else begin
      v_label = lab_q[2];
    end
    v_unan = all_eq;
    v_tie  = ~any_eq & multi;
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    taken_d     = taken_q;
    got_d       = got_q;
    lab_d       = lab_q;
    res_d       = res_q;
    frame_cnt_d = frame_cnt_q;
    proto_err_d = proto_err_q;
    f_valid     = 3'b000;
    r_ready     = 3'b000;
    r_hs        = 3'b000;
    s_ready     = 1'b0;
    s_hs        = 1'b0;
    m_valid     = 1'b0;

    case (state_q)
      S_IDLE: begin
        mask_d  = (en_mask == 3'b000) ? 3'b111 : en_mask;
        state_d = S_FEED;
      end

      S_FEED: begin
        f_valid = {3{s_axis.tvalid}} & mask_q & ~taken_q;
        // Ready must not look at tvalid, so it is formed purely from per-copy progress.
        s_ready = &(~mask_q | taken_q | f_ready);
        s_hs    = s_axis.tvalid & s_ready;
        if (s_hs) begin
          taken_d = 3'b000;
          if (s_axis.tlast) begin
            state_d = S_COLLECT;
          end
        end else begin
          taken_d = taken_q | (f_valid & f_ready);
        end
      end

      S_COLLECT: begin
        r_ready = mask_q & ~got_q;
        r_hs    = r_ready & r_valid;
        got_d   = got_q | r_hs;
        for (int k = 0; k < 3; k++) begin
          if (r_hs[k]) begin
            lab_d[k] = r_lab[k];
          end
        end
        if (|(r_hs & ~r_last)) begin
          proto_err_d = 1'b1;
        end
        if ((got_d & mask_q) == mask_q) begin
          state_d = S_VOTE;
        end
      end

      S_VOTE: begin
        res_d   = {v_tie, v_unan, v_label};
        state_d = S_OUT;
      end

      S_OUT: begin
        m_valid = 1'b1;
        if (m_axis.tready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          got_d       = 3'b000;
          taken_d     = 3'b000;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mask_q      <= 3'b111;
      taken_q     <= 3'b000;
      got_q       <= 3'b000;
      res_q       <= '0;
      frame_cnt_q <= 16'd0;
      proto_err_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        lab_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      taken_q     <= taken_d;
      got_q       <= got_d;
      res_q       <= res_d;
      frame_cnt_q <= frame_cnt_d;
      proto_err_q <= proto_err_d;
      for (int k = 0; k < 3; k++) begin
        lab_q[k] <= lab_d[k];
      end
    end
  end

  assign s_axis.tready = s_ready;

  assign f1_axis.tdata  = s_axis.tdata;
  assign f1_axis.tkeep  = s_axis.tkeep;
  assign f1_axis.tlast  = s_axis.tlast;
  assign f1_axis.tvalid = f_valid[0];
  assign f2_axis.tdata  = s_axis.tdata;
  assign f2_axis.tkeep  = s_axis.tkeep;
  assign f2_axis.tlast  = s_axis.tlast;
  assign f2_axis.tvalid = f_valid[1];
  assign f3_axis.tdata  = s_axis.tdata;
  assign f3_axis.tkeep  = s_axis.tkeep;
  assign f3_axis.tlast  = s_axis.tlast;
  assign f3_axis.tvalid = f_valid[2];

  assign r1_axis.tready = r_ready[0];
  assign r2_axis.tready = r_ready[1];
  assign r3_axis.tready = r_ready[2];

  assign m_axis.tdata  = {{(DATA_WIDTH-CLASS_WIDTH-2){1'b0}}, res_q};
  assign m_axis.tkeep  = {KEEP_WIDTH{1'b1}};
  assign m_axis.tlast  = 1'b1;
  assign m_axis.tvalid = m_valid;

  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ensemble_vote_ctrl.sv
// Scoreboard bench for ensemble_vote_ctrl: feature copies and vote words are recorded by a
// negedge monitor and compared against bench-computed expectations in each scenario task.
module tb_ensemble_vote_ctrl;
  localparam int DW = 32;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] en_mask = 3'b111;

  ensemble_vote_ctrl_if #(.DW(DW), .KW(KW)) s_if ();
  ensemble_vote_ctrl_if #(.DW(DW), .KW(KW)) f1_if ();
  ensemble_vote_ctrl_if #(.DW(DW), .KW(KW)) f2_if ();
  ensemble_vote_ctrl_if #(.DW(DW), .KW(KW)) f3_if ();
  ensemble_vote_ctrl_if #(.DW(DW), .KW(KW)) r1_if ();
  ensemble_vote_ctrl_if #(.DW(DW), .KW(KW)) r2_if ();
  ensemble_vote_ctrl_if #(.DW(DW), .KW(KW)) r3_if ();
  ensemble_vote_ctrl_if #(.DW(DW), .KW(KW)) m_if ();

  logic [15:0] frame_cnt;
  logic        busy, proto_err;

  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [2:0]    f_rdy = 3'b111;
  logic [2:0]    r_valid = 3'b000, r_last = 3'b111;
  logic [DW-1:0] r_data [3];
  logic          m_rdy = 1'b1;
  logic [2:0]    r_rdy, f_val;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  logic [2:0] cur_mask = 3'b111;

  logic [32:0]     obs_feat [3][$];
  logic [32:0]     exp_feat [3][$];
  logic [DW+KW:0]  obs_m [$];
  logic [DW-1:0]   exp_m [$];

  assign s_if.tdata  = s_tdata;
  assign s_if.tkeep  = 4'hF;
  assign s_if.tvalid = s_tvalid;
  assign s_if.tlast  = s_tlast;
  assign f1_if.tready = f_rdy[0];
  assign f2_if.tready = f_rdy[1];
  assign f3_if.tready = f_rdy[2];
  assign r1_if.tdata = r_data[0];
  assign r2_if.tdata = r_data[1];
  assign r3_if.tdata = r_data[2];
  assign r1_if.tkeep = 4'hF;
  assign r2_if.tkeep = 4'hF;
  assign r3_if.tkeep = 4'hF;
  assign r1_if.tvalid = r_valid[0];
  assign r2_if.tvalid = r_valid[1];
  assign r3_if.tvalid = r_valid[2];
  assign r1_if.tlast = r_last[0];
  assign r2_if.tlast = r_last[1];
  assign r3_if.tlast = r_last[2];
  assign m_if.tready = m_rdy;
  assign r_rdy = {r3_if.tready, r2_if.tready, r1_if.tready};
  assign f_val = {f3_if.tvalid, f2_if.tvalid, f1_if.tvalid};

  ensemble_vote_ctrl #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_mask   (en_mask),
    .s_axis    (s_if),
    .f1_axis   (f1_if),
    .f2_axis   (f2_if),
    .f3_axis   (f3_if),
    .r1_axis   (r1_if),
    .r2_axis   (r2_if),
    .r3_axis   (r3_if),
    .m_axis    (m_if),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  // Handshakes seen mid-cycle are the ones the next rising edge completes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (f1_if.tvalid && f1_if.tready) obs_feat[0].push_back({f1_if.tlast, f1_if.tdata});
      if (f2_if.tvalid && f2_if.tready) obs_feat[1].push_back({f2_if.tlast, f2_if.tdata});
      if (f3_if.tvalid && f3_if.tready) obs_feat[2].push_back({f3_if.tlast, f3_if.tdata});
      if (m_if.tvalid && m_if.tready) obs_m.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] vote_model(input logic [2:0] m, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] c);
    logic [7:0] lab [3];
    int n, best, bestcnt, cnt;
    lab[0] = a; lab[1] = b; lab[2] = c;
    n = 0; best = 0; bestcnt = 0;
    for (int i = 0; i < 3; i++) if (m[i]) n++;
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        cnt = 0;
        for (int j = 0; j < 3; j++) if (m[j] && lab[j] == lab[i]) cnt++;
        if (cnt > bestcnt) begin bestcnt = cnt; best = i; end
      end
    end
    if (bestcnt >= 2 || n == 1) return {22'd0, 1'b0, (bestcnt == n), lab[best]};
    return {22'd0, 1'b1, 1'b0, lab[best]};
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic last);
    int t;
    t = 0;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_if.tready) break;
      t++;
      if (t > 200) begin
        total++; bad++;
        $display("FAIL s_beat_timeout got_ready=0 need_ready=1");
        break;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic push_feat(input int n, input logic [31:0] base);
    for (int k = 0; k < 3; k++)
      if (cur_mask[k])
        for (int i = 0; i < n; i++) exp_feat[k].push_back({(i == n - 1), base + 32'(i)});
  endtask

  task automatic check_feat();
    logic [32:0] o, e;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_feat[k].size() != exp_feat[k].size()) begin
        bad++;
        $display("FAIL feat%0d_count got=%0d exp=%0d", k + 1, obs_feat[k].size(), exp_feat[k].size());
      end
      while (obs_feat[k].size() > 0 && exp_feat[k].size() > 0) begin
        o = obs_feat[k].pop_front();
        e = exp_feat[k].pop_front();
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL feat%0d_beat got=%h exp=%h", k + 1, o, e);
        end
      end
      obs_feat[k].delete();
      exp_feat[k].delete();
    end
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    push_feat(n, base);
    for (int i = 0; i < n; i++) send_beat(base + 32'(i), (i == n - 1));
    check_feat();
  endtask

  task automatic drive_results(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                               input int d0, input int d1, input int d2, input logic last0);
    logic [7:0] lab [3];
    int dly [3];
    logic [2:0] done;
    int c;
    lab[0] = l0; lab[1] = l1; lab[2] = l2;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    exp_m.push_back(vote_model(cur_mask, l0, l1, l2));
    done = ~cur_mask;
    c = 0;
    while (done != 3'b111 && c < 200) begin
      for (int k = 0; k < 3; k++)
        if (!done[k] && c >= dly[k]) begin
          r_valid[k] = 1'b1;
          r_data[k]  = {24'hA5C3E1, lab[k]};
          r_last[k]  = (k == 0) ? last0 : 1'b1;
        end
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (r_valid[k] && r_rdy[k]) done[k] = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) if (done[k]) r_valid[k] = 1'b0;
      c++;
    end
    r_last = 3'b111;
    total++;
    if (done != 3'b111) begin
      bad++;
      $display("FAIL results_accept got=%b exp=111", done);
    end
  endtask

  task automatic wait_out(input logic [2:0] next_mask);
    logic [DW+KW:0] o;
    logic [DW-1:0]  e;
    int t;
    en_mask = next_mask;
    t = 0;
    while (obs_m.size() == 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    total++;
    if (obs_m.size() == 0) begin
      bad++;
      $display("FAIL m_timeout got_words=0 exp_words=1");
      exp_m.delete();
    end else begin
      o = obs_m.pop_front();
      e = (exp_m.size() > 0) ? exp_m.pop_front() : 32'hDEAD_BEEF;
      exp_frames++;
      if (o !== {1'b1, 4'hF, e}) begin
        bad++;
        $display("FAIL m_word got=%h exp=%h", o, {1'b1, 4'hF, e});
      end
      total++;
      if (frame_cnt !== 16'(exp_frames)) begin
        bad++;
        $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames);
      end
    end
    cur_mask = (next_mask == 3'b000) ? 3'b111 : next_mask;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({s_if.tready, f_val, r_rdy, m_if.tvalid, busy, proto_err} !== 10'd0) begin
      bad++;
      $display("FAIL %s_outputs got=%b exp=0", tag,
               {s_if.tready, f_val, r_rdy, m_if.tvalid, busy, proto_err});
    end
    total++;
    if (frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL %s_frame_cnt got=%0d exp=0", tag, frame_cnt);
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    send_frame(4, 32'h1000_0000);
    drive_results(8'd5, 8'd5, 8'd5, 0, 0, 0, 1'b1);
    wait_out(3'b111);
  endtask

  task automatic test_backpressure();
    push_feat(6, 32'h2000_0000);
    send_beat(32'h2000_0000, 1'b0);
    send_beat(32'h2000_0001, 1'b0);
    f_rdy[1] = 1'b0;
    s_tdata = 32'h2000_0002; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (s_if.tready !== 1'b0) begin
        bad++;
        $display("FAIL stall_s_ready cyc=%0d got=%b exp=0", i, s_if.tready);
      end
      @(posedge clk); #1;
    end
    f_rdy[1] = 1'b1;
    @(negedge clk);
    total++;
    if (s_if.tready !== 1'b1) begin
      bad++;
      $display("FAIL release_s_ready got=%b exp=1", s_if.tready);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    for (int i = 3; i < 6; i++) send_beat(32'h2000_0000 + 32'(i), (i == 5));
    check_feat();
    drive_results(8'd1, 8'd1, 8'd1, 1, 0, 2, 1'b1);
    wait_out(3'b111);
  endtask

  task automatic test_vote();
    send_frame(2, 32'h3000_0000);
    drive_results(8'd7, 8'd3, 8'd7, 10, 2, 5, 1'b1);
    wait_out(3'b111);
    send_frame(3, 32'h3100_0000);
    drive_results(8'd1, 8'd2, 8'd3, 0, 0, 0, 1'b1);
    wait_out(3'b010);
  endtask

  task automatic test_mask();
    send_frame(3, 32'h4000_0000);
    drive_results(8'd0, 8'd9, 8'd0, 0, 0, 0, 1'b1);
    wait_out(3'b000);
    send_frame(2, 32'h4100_0000);
    drive_results(8'd4, 8'd4, 8'd6, 3, 0, 1, 1'b1);
    wait_out(3'b111);
  endtask

  task automatic test_out_stall();
    int t;
    m_rdy = 1'b0;
    send_frame(2, 32'h5000_0000);
    drive_results(8'd12, 8'd12, 8'd40, 0, 1, 0, 1'b0);
    t = 0;
    while (!m_if.tvalid && t < 20) begin @(posedge clk); #1; t++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_m[0]) begin
        bad++;
        $display("FAIL stall_m_hold cyc=%0d got=%b/%h exp=1/%h", i, m_if.tvalid, m_if.tdata, exp_m[0]);
      end
      total++;
      if (s_if.tready !== 1'b0) begin
        bad++;
        $display("FAIL stall_no_s_ready cyc=%0d got=%b exp=0", i, s_if.tready);
      end
      @(posedge clk); #1;
    end
    m_rdy = 1'b1;
    wait_out(3'b111);
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("FAIL proto_err_set got=%b exp=1", proto_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] nm;
    for (int f = 0; f < 4; f++) begin
      send_frame(int'($urandom_range(1, 5)), 32'h6000_0000 + 32'(f << 8));
      drive_results(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b1);
      nm = (f == 3) ? 3'b111 : 3'($urandom_range(0, 7));
      wait_out(nm);
    end
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("FAIL proto_err_sticky got=%b exp=1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    send_frame(2, 32'h7000_0000);
    r_data[0] = {24'hA5C3E1, 8'd77}; r_last[0] = 1'b1; r_valid[0] = 1'b1;
    @(posedge clk); #1;
    r_valid[0] = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL collect_busy got=%b exp=1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int k = 0; k < 3; k++) begin obs_feat[k].delete(); exp_feat[k].delete(); end
    obs_m.delete();
    exp_m.delete();
    exp_frames = 0;
    en_mask = 3'b111;
    cur_mask = 3'b111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(3, 32'h7100_0000);
    drive_results(8'd2, 8'd2, 8'd9, 0, 1, 0, 1'b1);
    wait_out(3'b111);
    total++;
    if (proto_err !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_proto_err got=%b exp=0", proto_err);
    end
  endtask

  initial begin
    r_data[0] = '0; r_data[1] = '0; r_data[2] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_vote();
    test_mask();
    test_out_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
